// File: rtl/jpeg_huff_pkg.sv
// Shared JPEG Huffman definitions: encoder FSM states and the luminance DC code table.
// Used by dc_huffman_encoder (optional category-11 support via DC_HUFF_ENC_CAT11_EN).
package jpeg_huff_pkg;

    typedef enum logic [1:0] {IDLE, CODE, AMP} state_t;

    localparam int MAX_CODE_LEN = 9;
    localparam int CAT_W        = 4;

    // Codes are right-aligned; only the low dc_len(cat) bits are sent, MSB first.
    function automatic logic [MAX_CODE_LEN-1:0] dc_code(input logic [CAT_W-1:0] cat);
        case (cat)
            4'd0:    return 9'b000000000;
            4'd1:    return 9'b000000010;
            4'd2:    return 9'b000000011;
            4'd3:    return 9'b000000100;
            4'd4:    return 9'b000000101;
            4'd5:    return 9'b000000110;
            4'd6:    return 9'b000001110;
            4'd7:    return 9'b000011110;
            4'd8:    return 9'b000111110;
            4'd9:    return 9'b001111110;
            4'd10:   return 9'b011111110;
            4'd11:   return 9'b111111110;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic logic [CAT_W-1:0] dc_len(input logic [CAT_W-1:0] cat);
        case (cat)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return (cat == 4'd0) ? 4'd2 : 4'd3;
            4'd6:    return 4'd4;
            4'd7:    return 4'd5;
            4'd8:    return 4'd6;
            4'd9:    return 4'd7;
            4'd10:   return 4'd8;
            4'd11:   return 4'd9;
            default: return 4'd2;
        endcase
    endfunction

endpackage

// File: rtl/dc_category.sv
// Combinational magnitude category and amplitude-bit formation for a two's-complement difference.
// Shared by the DC encoder (DC_HUFF_ENC_CAT11_EN aware caller) and the future AC encoder.
module dc_category
    import jpeg_huff_pkg::*;
#(
    parameter int DIFF_W = 12
) (
    input  logic [DIFF_W-1:0] diff,
    output logic [CAT_W-1:0]  cat,
    output logic [DIFF_W-1:0] amp
);

    logic [DIFF_W-1:0] mag;

    always_comb begin
        mag = diff[DIFF_W-1] ? -diff : diff;
        cat = '0;
        for (int i = 0; i < DIFF_W; i++) begin
            if (mag[i]) cat = CAT_W'(i + 1);
        end
        // Negative values send the ones-complement of |diff|, i.e. diff-1.
        amp = diff[DIFF_W-1] ? diff - DIFF_W'(1) : diff;
    end

endmodule

// File: rtl/dc_huffman_encoder.sv
// Bit-serial DPCM + luminance DC Huffman encoder, one code/amplitude bit per handshake.
// Define DC_HUFF_ENC_CAT11_EN to emit category 11; otherwise differences clamp to cat 10.
module dc_huffman_encoder
    import jpeg_huff_pkg::*;
#(
    parameter int DC_W = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DC_W-1:0] dc_in,
    input  logic            dc_valid,
    output logic            dc_ready,
    input  logic            pred_clr,
    output logic            bit_out,
    output logic            bit_valid,
    input  logic            bit_ready,
    output logic            last_bit,
    output logic            sat_err
);

    localparam int DIFF_W = DC_W + 1;
    localparam logic [CAT_W-1:0] ONE = CAT_W'(1);

    state_t state, state_next;

    logic [DC_W-1:0]         pred;
    logic [DIFF_W-1:0]       pred_x, diff, diff_c, amp_c, amp_q;
    logic [CAT_W-1:0]        cat_c, cat_q, cnt;
    logic [MAX_CODE_LEN-1:0] code_q;
    logic                    sat, accept, xfer, cnt_zero;

    assign dc_ready = (state == IDLE) && !rst;
    assign accept   = dc_valid && dc_ready;
    assign xfer     = bit_valid && bit_ready;
    assign cnt_zero = (cnt == '0);

    assign pred_x = pred_clr ? '0 : {pred[DC_W-1], pred};
    assign diff   = {dc_in[DC_W-1], dc_in} - pred_x;

`ifdef DC_HUFF_ENC_CAT11_EN
    assign diff_c = diff;
    assign sat    = 1'b0;
`else
    // The downstream decoder has no category 11, so clamp to the largest cat-10 value.
    localparam logic [DIFF_W-1:0] LIM_POS = DIFF_W'((1 << (DC_W - 1)) - 1);
    localparam logic [DIFF_W-1:0] LIM_NEG = -LIM_POS;
    logic [DIFF_W-1:0] mag;
    assign mag    = diff[DIFF_W-1] ? -diff : diff;
    assign sat    = mag > LIM_POS;
    assign diff_c = !sat ? diff : (diff[DIFF_W-1] ? LIM_NEG : LIM_POS);
`endif

    dc_category #(.DIFF_W(DIFF_W)) u_cat (
        .diff (diff_c),
        .cat  (cat_c),
        .amp  (amp_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bit_valid  = 1'b0;
        bit_out    = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: if (accept) state_next = CODE;
            CODE: begin
                bit_valid = 1'b1;
                bit_out   = code_q[cnt];
                last_bit  = cnt_zero && (cat_q == '0);
                if (xfer && cnt_zero) state_next = (cat_q == '0) ? IDLE : AMP;
            end
            AMP: begin
                bit_valid = 1'b1;
                bit_out   = amp_q[cnt];
                last_bit  = cnt_zero;
                if (xfer && cnt_zero) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt indexes the bit on the wire; it reloads with cat-1 when CODE hands over to AMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred    <= '0;
            sat_err <= 1'b0;
            cnt     <= '0;
            cat_q   <= '0;
            code_q  <= '0;
            amp_q   <= '0;
        end else begin
            sat_err <= accept && sat;
            if (accept) begin
                pred   <= dc_in;
                cat_q  <= cat_c;
                code_q <= dc_code(cat_c);
                amp_q  <= amp_c;
                cnt    <= dc_len(cat_c) - ONE;
            end else begin
                if (pred_clr) pred <= '0;
                if (xfer) cnt <= cnt_zero ? cat_q - ONE : cnt - ONE;
            end
        end
    end

endmodule

// File: tb/tb_dc_huffman_encoder.sv
// Scoreboard bench for dc_huffman_encoder; expectations follow DC_HUFF_ENC_CAT11_EN if defined.
module tb_dc_huffman_encoder;

    logic        clk = 1'b0;
    logic        rst, dc_valid, dc_ready, pred_clr;
    logic        bit_out, bit_valid, bit_ready, last_bit, sat_err;
    logic [10:0] dc_in;

    always #5 clk = ~clk;

    dc_huffman_encoder #(.DC_W(11)) dut (
        .clk(clk), .rst(rst), .dc_in(dc_in), .dc_valid(dc_valid), .dc_ready(dc_ready),
        .pred_clr(pred_clr), .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .last_bit(last_bit), .sat_err(sat_err)
    );

    int checks = 0;
    int errors = 0;
    int pred_m = 0;
    logic [1:0] q[$];   // {bit, last}
    string codes[12] = '{"00", "010", "011", "100", "101", "110", "1110", "11110",
                         "111110", "1111110", "11111110", "111111110"};

    task automatic model(input int dc, input bit clr, output string s, output bit sat);
        int d, a, cat, v;
        d   = dc - (clr ? 0 : pred_m);
        sat = 1'b0;
`ifndef DC_HUFF_ENC_CAT11_EN
        if (d > 1023)  begin d = 1023;  sat = 1'b1; end
        if (d < -1023) begin d = -1023; sat = 1'b1; end
`endif
        a = (d < 0) ? -d : d;
        cat = 0;
        while (a > 0) begin cat++; a = a >> 1; end
        v = (d > 0) ? d : d - 1;
        s = codes[cat];
        for (int i = cat - 1; i >= 0; i--) s = {s, v[i] ? "1" : "0"};
    endtask

    task automatic push_bits(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back({s[i] == 8'h31, i == s.len() - 1});
    endtask

    // Waits for dc_ready, presents one coefficient and checks first-bit latency and sat_err.
    task automatic send(input int dc, input bit clr, input string exp);
        string s;
        bit    sat;
        int    w = 0;
        while (dc_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (dc_ready !== 1'b1) begin errors++; $display("FAIL send_ready dc=%0d got %b want 1", dc, dc_ready); end
        model(dc, clr, s, sat);
        push_bits((exp != "") ? exp : s);
        pred_m   = dc;
        dc_in    = 11'(dc);
        dc_valid = 1'b1;
        pred_clr = clr;
        @(negedge clk);
        dc_valid = 1'b0;
        pred_clr = 1'b0;
        dc_in    = 11'($urandom);
        checks++;
        if (bit_valid !== 1'b1) begin errors++; $display("FAIL latency dc=%0d bit_valid=%b want 1", dc, bit_valid); end
        checks++;
        if (sat_err !== sat) begin errors++; $display("FAIL sat_err dc=%0d got %b want %b", dc, sat_err, sat); end
    endtask

    // mode 0: ready always; mode 1: ready pattern 1,0,0 repeating. Stops after max_bits pops.
    task automatic drain(input int mode, input int max_bits, input bit check_done);
        int popped = 0;
        int cyc    = 0;
        while (q.size() > 0 && popped < max_bits) begin
            if (cyc > 200) begin
                checks++; errors++;
                $display("FAIL drain_timeout remaining=%0d want 0", q.size());
                q.delete();
                break;
            end
            bit_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (cyc > 0) begin
                checks++;
                if (sat_err !== 1'b0) begin errors++; $display("FAIL sat_pulse_len got %b want 0", sat_err); end
            end
            checks++;
            if (bit_valid !== 1'b1) begin
                errors++;
                $display("FAIL bit_valid cyc=%0d got %b want 1", cyc, bit_valid);
                q.delete();
                break;
            end
            checks++;
            if ({bit_out, last_bit} !== q[0]) begin
                errors++;
                $display("FAIL bit cyc=%0d got bit=%b last=%b want bit=%b last=%b",
                         cyc, bit_out, last_bit, q[0][1], q[0][0]);
            end
            if (bit_ready) begin void'(q.pop_front()); popped++; end
            cyc++;
            @(negedge clk);
        end
        if (check_done) begin
            checks++;
            if (dc_ready !== 1'b1 || bit_valid !== 1'b0) begin
                errors++;
                $display("FAIL done ready=%b valid=%b want ready=1 valid=0", dc_ready, bit_valid);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; dc_valid = 1'b0; pred_clr = 1'b0; bit_ready = 1'b0; dc_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (dc_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", dc_ready); end
        checks++;
        if ({bit_out, bit_valid, last_bit, sat_err} !== 4'b0) begin
            errors++;
            $display("FAIL rst_outputs got %b want 0000", {bit_out, bit_valid, last_bit, sat_err});
        end
        rst = 1'b0;
        pred_m = 0;
        @(negedge clk);
        checks++;
        if (dc_ready !== 1'b1 || bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst ready=%b valid=%b want ready=1 valid=0", dc_ready, bit_valid);
        end
    endtask

    task automatic test_basic;
        send(5, 1'b0, "100101"); drain(0, 99, 1'b1);
        send(3, 1'b0, "01101");  drain(0, 99, 1'b1);
        send(3, 1'b0, "00");     drain(0, 99, 1'b1);
    endtask

    task automatic test_saturation;
        send(200, 1'b0, ""); drain(0, 99, 1'b1);
`ifdef DC_HUFF_ENC_CAT11_EN
        send(-1024, 1'b1, "11111111001111111111");
`else
        send(-1024, 1'b1, "111111100000000000");
`endif
        drain(0, 99, 1'b1);
    endtask

    task automatic test_backpressure;
        send(5, 1'b1, "100101"); drain(1, 99, 1'b1);
    endtask

    task automatic test_back_to_back;
        int vals[6] = '{1023, -1024, 0, -1, 1, 512};
        foreach (vals[i]) begin send(vals[i], 1'b0, ""); drain(0, 99, 1'b1); end
        for (int i = 0; i < 8; i++) begin
            send(int'($urandom_range(0, 2047)) - 1024, 1'(i == 3), "");
            drain(i % 2, 99, 1'b1);
        end
    endtask

    task automatic test_reset_mid_amp;
        send(20, 1'b1, "11010100");
        drain(0, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bit_valid !== 1'b0 || dc_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_amp_rst valid=%b ready=%b want 0 0", bit_valid, dc_ready);
        end
        q.delete();
        rst = 1'b0;
        pred_m = 0;
        @(negedge clk);
        send(7, 1'b0, "100111"); drain(0, 99, 1'b1);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_amp;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
